// File: rtl/adder_pkg.sv
// adder_pkg: stage-count and width-legality helpers for the chunked pipelined adder
// No ports; shared functions only.
package adder_pkg;
    function automatic int num_stages(input int data_width, input int chunk_width);
        return (chunk_width > 0) ? data_width / chunk_width : 0;
    endfunction
    function automatic bit widths_ok(input int data_width, input int chunk_width);
        return chunk_width > 0 && data_width >= chunk_width && data_width % chunk_width == 0;
    endfunction
endpackage

// File: rtl/adder_chunk_stage.sv
// adder_chunk_stage: one pipeline register stage adding chunk STAGE_INDEX with valid/ready flow control
// Ports: i_valid/o_ready upstream handshake, i_ready/o_valid downstream handshake,
//        i_a/i_b operands, i_sum lower sum bits so far, i_carry carry into this chunk,
//        o_a/o_b/o_sum/o_carry registered stage contents.
module adder_chunk_stage
    import adder_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int CHUNK_WIDTH = 8,
    parameter int STAGE_INDEX = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    input  logic [DATA_WIDTH-1:0] i_sum,
    input  logic                  i_carry,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_a,
    output logic [DATA_WIDTH-1:0] o_b,
    output logic [DATA_WIDTH-1:0] o_sum,
    output logic                  o_carry
);
    localparam int LO = STAGE_INDEX * CHUNK_WIDTH;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [DATA_WIDTH-1:0] r_sum;
    logic                  r_carry;
    logic [CHUNK_WIDTH:0]  w_chunk;
    assign w_chunk = {1'b0, i_a[LO +: CHUNK_WIDTH]} + {1'b0, i_b[LO +: CHUNK_WIDTH]}
                   + {{CHUNK_WIDTH{1'b0}}, i_carry};
    // Loadable when empty or when the current content leaves this cycle.
    assign o_ready = !r_valid || i_ready;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
        end else if (o_ready) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_a                    <= i_a;
                r_b                    <= i_b;
                r_sum                  <= i_sum;
                r_sum[LO +: CHUNK_WIDTH] <= w_chunk[CHUNK_WIDTH-1:0];
                r_carry                <= w_chunk[CHUNK_WIDTH];
            end
        end
    end
    assign o_valid = r_valid;
    assign o_a     = r_a;
    assign o_b     = r_b;
    assign o_sum   = r_sum;
    assign o_carry = r_carry;
endmodule

// File: rtl/pipelined_chunk_adder.sv
// pipelined_chunk_adder: valid/ready adder computing one CHUNK_WIDTH slice per register stage
// Ports: in_valid/in_ready + data_in_a/data_in_b/carry_in upstream beat;
//        out_valid/out_ready + data_out_a/data_out_b/sum/carry_out/overflow result beat.
module pipelined_chunk_adder
    import adder_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int CHUNK_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] data_in_a,
    input  logic [DATA_WIDTH-1:0] data_in_b,
    input  logic                  carry_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] data_out_a,
    output logic [DATA_WIDTH-1:0] data_out_b,
    output logic [DATA_WIDTH-1:0] sum,
    output logic                  carry_out,
    output logic                  overflow
);
    localparam int NUM_STAGES = num_stages(DATA_WIDTH, CHUNK_WIDTH);
    localparam int MSB        = DATA_WIDTH - 1;
    if (!widths_ok(DATA_WIDTH, CHUNK_WIDTH)) begin : g_bad_widths
        $error("DATA_WIDTH must be a positive multiple of CHUNK_WIDTH");
    end
    // Index k is the input side of stage k; index NUM_STAGES is the output side of the last stage.
    logic                  w_valid [NUM_STAGES+1];
    logic                  w_ready [NUM_STAGES+1];
    logic [DATA_WIDTH-1:0] w_a     [NUM_STAGES+1];
    logic [DATA_WIDTH-1:0] w_b     [NUM_STAGES+1];
    logic [DATA_WIDTH-1:0] w_sum   [NUM_STAGES+1];
    logic                  w_carry [NUM_STAGES+1];
    assign w_valid[0]          = in_valid;
    assign w_a[0]              = data_in_a;
    assign w_b[0]              = data_in_b;
    assign w_sum[0]            = '0;
    assign w_carry[0]          = carry_in;
    assign w_ready[NUM_STAGES] = out_ready;
    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        adder_chunk_stage #(
            .DATA_WIDTH (DATA_WIDTH),
            .CHUNK_WIDTH(CHUNK_WIDTH),
            .STAGE_INDEX(k)
        ) u_stage (
            .clk    (clk),
            .rst    (rst),
            .i_valid(w_valid[k]),
            .o_ready(w_ready[k]),
            .i_a    (w_a[k]),
            .i_b    (w_b[k]),
            .i_sum  (w_sum[k]),
            .i_carry(w_carry[k]),
            .o_valid(w_valid[k+1]),
            .i_ready(w_ready[k+1]),
            .o_a    (w_a[k+1]),
            .o_b    (w_b[k+1]),
            .o_sum  (w_sum[k+1]),
            .o_carry(w_carry[k+1])
        );
    end
    assign in_ready   = w_ready[0] && !rst;
    assign out_valid  = w_valid[NUM_STAGES];
    assign data_out_a = w_a[NUM_STAGES];
    assign data_out_b = w_b[NUM_STAGES];
    assign sum        = w_sum[NUM_STAGES];
    assign carry_out  = w_carry[NUM_STAGES];
    // Signed overflow: like-signed operands producing a result of the other sign.
    assign overflow   = (w_a[NUM_STAGES][MSB] == w_b[NUM_STAGES][MSB])
                     && (w_sum[NUM_STAGES][MSB] != w_a[NUM_STAGES][MSB]);
endmodule

// File: tb/tb_pipelined_chunk_adder.sv
// tb_pipelined_chunk_adder: scoreboard bench for the 4-stage 32-bit chunked adder
module tb_pipelined_chunk_adder;
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] s;
        logic        c;
        logic        v;
    } beat_t;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_in_a;
    logic [31:0] data_in_b;
    logic        carry_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_out_a;
    logic [31:0] data_out_b;
    logic [31:0] sum;
    logic        carry_out;
    logic        overflow;
    beat_t       q[$];
    beat_t       mon_got;
    beat_t       mon_exp;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          first_pop = -1;
    int          last_pop = 0;
    bit          rand_ready = 1'b0;
    pipelined_chunk_adder #(.DATA_WIDTH(32), .CHUNK_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in_a (data_in_a),
        .data_in_b (data_in_b),
        .carry_in  (carry_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out_a(data_out_a),
        .data_out_b(data_out_b),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    function automatic beat_t model(input logic [31:0] a, input logic [31:0] b, input logic c);
        beat_t r;
        logic [32:0] full;
        full = {1'b0, a} + {1'b0, b} + {32'd0, c};
        r.a = a;
        r.b = b;
        r.s = full[31:0];
        r.c = full[32];
        r.v = (a[31] == b[31]) && (full[31] != a[31]);
        return r;
    endfunction
    function automatic beat_t outs();
        return {data_out_a, data_out_b, sum, carry_out, overflow};
    endfunction
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            mon_got = outs();
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat: got sum %h with no beat outstanding", sum);
            end else begin
                mon_exp = q.pop_front();
                chk("beat", mon_got, mon_exp);
            end
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
        end
    end
    always @(posedge clk) begin
        if (rand_ready) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end
    task automatic send_exp(input beat_t e, input logic cin, output int waits);
        in_valid  = 1'b1;
        data_in_a = e.a;
        data_in_b = e.b;
        carry_in  = cin;
        waits     = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back(e);
                break;
            end
            waits++;
            if (waits > 200) begin
                total++;
                bad++;
                $display("FAIL send_timeout: got no in_ready after %0d cycles expected acceptance", waits);
                break;
            end
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin, output int waits);
        send_exp(model(a, b, cin), cin, waits);
    endtask
    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("drain", q.size(), 0);
        @(posedge clk);
        #1;
    endtask
    task automatic latency_check(input string name);
        repeat (3) begin
            @(negedge clk);
            chk({name, "_empty"}, out_valid, 1'b0);
        end
        @(negedge clk);
        chk({name, "_valid"}, out_valid, 1'b1);
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        int    w;
        int    k;
        beat_t sb[6];
        beat_t snap;
        rst       = 1'b1;
        in_valid  = 1'b0;
        data_in_a = '0;
        data_in_b = '0;
        carry_in  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {out_valid, outs()}, '0);
        chk("reset_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", in_ready, 1'b1);
        @(posedge clk);
        #1;
        send_exp('{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0}, 1'b0, w);
        latency_check("latency");
        chk("xor_carries", data_out_a ^ data_out_b ^ sum, 32'hFFFF_FFFE);
        @(posedge clk);
        #1;
        send_exp('{32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1}, 1'b0, w);
        send_exp('{32'h0000_00FF, 32'h0000_0000, 32'h0000_0100, 1'b0, 1'b0}, 1'b1, w);
        send_exp('{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1}, 1'b0, w);
        send_exp('{32'h1234_5678, 32'h8765_4321, 32'h9999_9999, 1'b0, 1'b0}, 1'b0, w);
        send_exp('{32'h0000_FFFF, 32'h0000_FFFF, 32'h0001_FFFF, 1'b0, 1'b0}, 1'b1, w);
        send_exp('{32'h00FF_FFFF, 32'h0000_0000, 32'h0100_0000, 1'b0, 1'b0}, 1'b1, w);
        drain();
        first_pop = -1;
        for (int i = 0; i < 100; i++) begin
            send($urandom, $urandom, 1'($urandom_range(0, 1)), w);
            chk("stream_no_wait", w, 0);
        end
        drain();
        chk("stream_rate", last_pop - first_pop, 99);
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) sb[i] = model(32'h1111_1111 * i, 32'h0F0F_0F0F + i, 1'(i));
        k = 0;
        for (int i = 0; i < 8; i++) begin
            in_valid  = (k < 6);
            data_in_a = sb[k % 6].a;
            data_in_b = sb[k % 6].b;
            carry_in  = 1'(k % 6);
            @(negedge clk);
            if (in_valid && in_ready) begin
                q.push_back(sb[k]);
                k++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("stall_accepted", k, 4);
        @(negedge clk);
        chk("stall_in_ready", in_ready, 1'b0);
        chk("stall_head", {out_valid, outs()}, {1'b1, sb[0]});
        snap = outs();
        repeat (3) @(negedge clk);
        chk("stall_hold", {out_valid, outs()}, {1'b1, snap});
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(sb[4].a, sb[4].b, 1'b0, w);
        send(sb[5].a, sb[5].b, 1'b1, w);
        drain();
        for (int i = 0; i < 3; i++) send(32'hA5A5_0000 + i, 32'h0000_5A5A, 1'b0, w);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b0);
        q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_flush", {out_valid, outs()}, '0);
        repeat (8) begin
            @(negedge clk);
            chk("rst_no_stale", out_valid, 1'b0);
        end
        @(posedge clk);
        #1;
        send_exp('{32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b0, 1'b0}, 1'b0, w);
        latency_check("post_rst_latency");
        drain();
        rand_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                send($urandom, $urandom, 1'($urandom_range(0, 1)), w);
            end else begin
                @(posedge clk);
                #1;
            end
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
